// File: rtl/mem_pkg.sv
// Shared types for the OTTER data-memory path: access size encoding,
// load/store unit FSM states and the local alignment helper.
package mem_pkg;

  // Access size as seen on req_size / mem_size; 2'b11 is the illegal code.
  typedef enum logic [1:0] {
    BYTE = 2'b00,
    HALF = 2'b01,
    WORD = 2'b10
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    WAIT  = 2'b10,
    RESP  = 2'b11
  } lsu_state_e;

  // True when an access of this size cannot be issued at this byte offset.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] addr_lo);
    logic bad;
    case (size)
      BYTE:    bad = 1'b0;
      HALF:    bad = addr_lo[0];
      WORD:    bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response and memory-side strobe bundle of the load/store unit.
//
// Request handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. req_ready is high only while the unit is idle;
// req_valid is ignored otherwise. The response is a single-cycle resp_valid
// pulse with no backpressure: the core must take it in that cycle.
interface load_store_unit_if #(
  parameter int BUS_WIDTH = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [BUS_WIDTH-1:0] req_addr;
  logic [BUS_WIDTH-1:0] req_wdata;
  logic [1:0]           req_size;
  logic                 req_unsigned;

  logic                 resp_valid;
  logic [BUS_WIDTH-1:0] resp_rdata;
  logic                 resp_error;

  logic                 mem_rd;
  logic                 mem_we;
  logic [BUS_WIDTH-1:0] mem_addr;
  logic [BUS_WIDTH-1:0] mem_wdata;
  logic [1:0]           mem_size;
  logic                 mem_sign;
  logic [BUS_WIDTH-1:0] mem_rdata;
  logic                 mem_error;

  // Core plus memory environment around the unit.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_rd, mem_we, mem_addr, mem_wdata, mem_size, mem_sign,
    output mem_rdata, mem_error
  );

  // The load/store unit itself.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_rd, mem_we, mem_addr, mem_wdata, mem_size, mem_sign,
    input  mem_rdata, mem_error
  );
endinterface

// File: rtl/load_aligner.sv
// Combinational load data extraction: picks the byte/halfword lane out of the
// raw memory word and sign- or zero-extends it to the bus width.
module load_aligner
  import mem_pkg::*;
#(
  parameter int BUS_WIDTH = 32
) (
  input  logic [BUS_WIDTH-1:0] raw,
  input  logic [1:0]           addr_lo,
  input  logic [1:0]           size,
  input  logic                 is_unsigned,
  output logic [BUS_WIDTH-1:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        ext_bit;

  // Select the lane, then extend from its MSB unless a zero-extending load.
  always_comb begin
    byte_sel = raw[{addr_lo, 3'b000} +: 8];
    half_sel = raw[{addr_lo[1], 4'b0000} +: 16];
    ext_bit  = 1'b0;
    case (size)
      BYTE: begin
        ext_bit = ~is_unsigned & byte_sel[7];
        data    = {{(BUS_WIDTH-8){ext_bit}}, byte_sel};
      end
      HALF: begin
        ext_bit = ~is_unsigned & half_sel[15];
        data    = {{(BUS_WIDTH-16){ext_bit}}, half_sel};
      end
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: initiator side of the OTTER data-memory interface.
// One request at a time: IDLE -> ISSUE -> (WAIT for loads) -> RESP -> IDLE.
// Optional macro LSU_LOCAL_ALIGN_CHECK_EN: reject misaligned/illegal requests
// in IDLE so they never reach memory (error response one cycle after accept).
module load_store_unit
  import mem_pkg::*;
#(
  parameter int BUS_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  load_store_unit_if.slave        bus,
  output lsu_state_e              state_o
);

  lsu_state_e           state_q, state_d;
  logic                 req_ready_q, req_ready_d;
  logic                 resp_valid_q, resp_valid_d;
  logic                 resp_error_q, resp_error_d;
  logic [BUS_WIDTH-1:0] resp_rdata_q, resp_rdata_d;
  logic                 mem_rd_q, mem_rd_d;
  logic                 mem_we_q, mem_we_d;
  logic [BUS_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [BUS_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]           mem_size_q, mem_size_d;
  logic                 mem_sign_q, mem_sign_d;
  // Kept past ISSUE so the WAIT cycle can align the returned word.
  logic [1:0]           addr_lo_q, addr_lo_d;
  logic [1:0]           size_q, size_d;
  logic                 uns_q, uns_d;

  logic                 local_err;
  logic [BUS_WIDTH-1:0] aligned_rdata;
  logic [BUS_WIDTH-1:0] lane_wdata;

  load_aligner #(.BUS_WIDTH(BUS_WIDTH)) u_load_aligner (
    .raw         (bus.mem_rdata),
    .addr_lo     (addr_lo_q),
    .size        (size_q),
    .is_unsigned (uns_q),
    .data        (aligned_rdata)
  );

  // Local alignment check on the incoming request, if enabled.
`ifdef LSU_LOCAL_ALIGN_CHECK_EN
  assign local_err = is_misaligned(bus.req_size, bus.req_addr[1:0]);
`else
  assign local_err = 1'b0;
`endif

  // Replicate store data into every lane it could land in.
  always_comb begin
    case (bus.req_size)
      BYTE:    lane_wdata = {(BUS_WIDTH/8){bus.req_wdata[7:0]}};
      HALF:    lane_wdata = {(BUS_WIDTH/16){bus.req_wdata[15:0]}};
      default: lane_wdata = bus.req_wdata;
    endcase
  end

  // Next-state and next-output logic; memory fields are nonzero only in ISSUE.
  always_comb begin
    state_d      = state_q;
    resp_valid_d = 1'b0;
    resp_error_d = 1'b0;
    resp_rdata_d = resp_rdata_q;
    mem_rd_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    mem_size_d   = 2'b00;
    mem_sign_d   = 1'b0;
    addr_lo_d    = addr_lo_q;
    size_d       = size_q;
    uns_d        = uns_q;
    case (state_q)
      IDLE: begin
        resp_rdata_d = '0;
        if (bus.req_valid) begin
          addr_lo_d = bus.req_addr[1:0];
          size_d    = bus.req_size;
          uns_d     = bus.req_unsigned;
          if (local_err) begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_error_d = 1'b1;
          end else begin
            state_d     = ISSUE;
            mem_rd_d    = ~bus.req_we;
            mem_we_d    = bus.req_we;
            mem_addr_d  = bus.req_addr;
            mem_wdata_d = lane_wdata;
            mem_size_d  = bus.req_size;
            mem_sign_d  = bus.req_unsigned;
          end
        end
      end
      ISSUE: begin
        if (bus.mem_error) begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          resp_error_d = 1'b1;
        end else if (mem_rd_q) begin
          state_d = WAIT;
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
        end
      end
      WAIT: begin
        state_d      = RESP;
        resp_valid_d = 1'b1;
        resp_rdata_d = aligned_rdata;
      end
      default: begin
        state_d      = IDLE;
        resp_rdata_d = '0;
      end
    endcase
    req_ready_d = (state_d == IDLE);
  end

  // State and registered outputs; reset drops any in-flight response.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_error_q <= 1'b0;
      resp_rdata_q <= '0;
      mem_rd_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_size_q   <= 2'b00;
      mem_sign_q   <= 1'b0;
      addr_lo_q    <= 2'b00;
      size_q       <= 2'b00;
      uns_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_error_q <= resp_error_d;
      resp_rdata_q <= resp_rdata_d;
      mem_rd_q     <= mem_rd_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_size_q   <= mem_size_d;
      mem_sign_q   <= mem_sign_d;
      addr_lo_q    <= addr_lo_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
    end
  end

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_error = resp_error_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.mem_rd     = mem_rd_q;
  // The write strobe is suppressed in the same cycle memory flags an error.
  assign bus.mem_we     = mem_we_q & ~bus.mem_error;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.mem_size   = mem_size_q;
  assign bus.mem_sign   = mem_sign_q;
  assign state_o        = state_q;

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Initiator side of the OTTER data-memory interface, placed between the multicycle core datapath and the data `memory` block. It accepts one load or store request at a time from the core and drives the memory strobe, address, size and data lines. For loads it waits out the one-cycle BRAM read latency, then extracts the byte or halfword from the raw word and sign- or zero-extends it. It returns a single-cycle response carrying either data or an error.

## Interface
- `BUS_WIDTH`, default 32: data and address width.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `req_valid` in 1: request strobe; sampled only while `req_ready`=1.
- `req_ready` out 1: high in IDLE only.
- `req_we` in 1: 1 = store, 0 = load.
- `req_addr` in BUS_WIDTH: byte address.
- `req_wdata` in BUS_WIDTH: store data, right-justified.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned` in 1: 1 = zero-extend loads (funct3[2]).
- `resp_valid` out 1: one-cycle completion pulse.
- `resp_rdata` out BUS_WIDTH: aligned, extended load data; 0 for stores and errors.
- `resp_error` out 1: qualified by `resp_valid`.
- `mem_rd` out 1: memory read strobe.
- `mem_we` out 1: memory write strobe.
- `mem_addr` out BUS_WIDTH: memory address.
- `mem_wdata` out BUS_WIDTH: lane-replicated store data.
- `mem_size` out 2: access size to memory.
- `mem_sign` out 1: equals latched `req_unsigned`.
- `mem_rdata` in BUS_WIDTH: raw word from memory, valid one cycle after `mem_rd`.
- `mem_error` in 1: combinational range/alignment error from memory.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE:** `req_ready`=1. When `req_valid`=1, latch we/addr/wdata/size/unsigned, then go to ISSUE. With the local check enabled and the request misaligned or illegal, go to RESP with error instead.
- **ISSUE:** `mem_addr`/`mem_size`/`mem_sign`/`mem_wdata` are driven from the latched fields. `mem_error` is sampled in this cycle.
  - Load: `mem_rd`=1 → WAIT.
  - Store: `mem_we` = !`mem_error` (combinational gate) → RESP.
  - Any `mem_error` sets the error flag. A load with error goes to RESP, not WAIT.
- **WAIT:** capture `mem_rdata`, align and extend it into the `resp_rdata` register → RESP.
- **RESP:** `resp_valid`=1 for exactly one cycle → IDLE. There is no backpressure; the core must accept the pulse.
- Store lane placement for `mem_wdata`:
  - byte: `wdata[7:0]` replicated to all four lanes.
  - half: `wdata[15:0]` replicated to both halves.
  - word: passed through unchanged.
- Load extraction:
  - byte: lane = addr[1:0], bits [8*lane+7:8*lane].
  - half: addr[1] selects [31:16] or [15:0].
  - word: raw word.
  - Extension: sign-extend from the MSB of the selected field unless `req_unsigned`=1.
- Local misalignment rules: size 11 always; word with addr[1:0]≠0; half with addr[0]=1.
- `req_valid` outside IDLE is ignored.
- Memory outputs are 0 in every state other than ISSUE. `mem_rd` and `mem_we` are never high together.

## Timing
- Reset values: state IDLE, `req_ready`=1. Zero: `resp_valid`, `resp_rdata`, `resp_error`, `mem_rd`, `mem_we`, `mem_addr`, `mem_wdata`, `mem_size`, `mem_sign`.
- Latency from the accepting edge (cycle 0):
  - Load: ISSUE in cycle 1, WAIT in cycle 2, `resp_valid` in cycle 3.
  - Store: `resp_valid` in cycle 2.
  - Local error: `resp_valid` in cycle 1.
- Issue rate: next request accepted in the cycle after RESP, so peak is one load per 4 cycles.
- `rst_n` low in any state returns to IDLE on that edge. The in-flight response is dropped and no strobe is asserted afterwards. A store in ISSUE at the reset edge still writes in that cycle.

## Configuration
- `LSU_LOCAL_ALIGN_CHECK_EN`
  - Defined: misaligned and illegal requests are detected in IDLE and never reach memory; error response arrives in cycle 1.
  - Undefined: every request goes through ISSUE, and errors come only from `mem_error`. `mem_rd` still pulses for erroring loads, while `mem_we` stays gated.

## Structure
- Shared package `mem_pkg` holds:
  - size enum: BYTE=00, HALF=01, WORD=10.
  - LSU state enum.
- One sub-module, `load_aligner`: combinational extract and extend (inputs: raw word, addr[1:0], size, unsigned).

## Test plan
- Store word 0xDEADBEEF @0x100 → in cycle 1 `mem_we`=1, `mem_addr`=0x100, `mem_size`=10, `mem_wdata`=0xDEADBEEF; `resp_valid` in cycle 2, `resp_error`=0.
- Store byte 0x5A @0x103 → `mem_wdata`=0x5A5A5A5A, `mem_size`=00.
- Load byte @0x103 with `mem_rdata`=0x80000000:
  - signed → `resp_rdata`=0xFFFFFF80 in cycle 3.
  - unsigned → 0x00000080.
- Load half signed @0x102 with `mem_rdata`=0x1234ABCD → 0x00001234. Same load @0x100 → 0xFFFFABCD.
- Load word @0x101:
  - Macro defined → `resp_valid`+`resp_error` in cycle 1, `mem_rd` never high.
  - Macro undefined → `mem_rd`=1 in cycle 1, error from `mem_error`.
- Store @0x2000 with `mem_error`=1 → `mem_we` stays 0, `resp_error`=1. Separately, `rst_n`=0 during WAIT → IDLE next cycle, no `resp_valid`, `req_ready`=1.
